// File: rtl/mem_copy_initiator_if.sv
// rtl/mem_copy_initiator_if.sv - data memory port bundle between a copy initiator and a memory
interface mem_copy_initiator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                    data_req;
    logic [ADDR_WIDTH-1:0]   data_addr;
    logic                    data_we;
    logic [DATA_WIDTH/8-1:0] data_be;
    logic [DATA_WIDTH-1:0]   data_wdata;
    logic                    data_gnt;
    logic                    data_rvalid;
    logic                    data_err;
    logic [DATA_WIDTH-1:0]   data_rdata;

    modport master (
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_err, data_rdata
    );

    modport slave (
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_err, data_rdata
    );
endinterface

// File: rtl/mem_copy_initiator.sv
// rtl/mem_copy_initiator.sv - block copy engine issuing one read then one write per word
module mem_copy_initiator #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len_words,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_addr,
    mem_copy_initiator_if.master  data_if
);
    localparam int                    BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  error_q, error_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            err_addr_q <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            err_addr_q <= err_addr_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        err_addr_d = err_addr_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        error_d    = error_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (len_words != '0) begin
                        src_d   = src_addr & ALIGN;
                        dst_d   = dst_addr & ALIGN;
                        cnt_d   = len_words;
                        state_d = S_RD_REQ;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_RD_REQ: if (data_if.data_gnt) state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (data_if.data_rvalid) begin
                    if (data_if.data_err) begin
                        error_d    = 1'b1;
                        err_addr_d = src_q;
                        state_d    = S_FINISH;
                    end else begin
                        wdata_d = data_if.data_rdata;
                        state_d = S_WR_REQ;
                    end
                end
            end
            S_WR_REQ: if (data_if.data_gnt) state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (data_if.data_rvalid) begin
                    if (data_if.data_err) begin
                        error_d    = 1'b1;
                        err_addr_d = dst_q;
                        state_d    = S_FINISH;
                    end else begin
                        // Pointers wrap silently modulo 2^ADDR_WIDTH
                        src_d   = src_q + STEP;
                        dst_d   = dst_q + STEP;
                        cnt_d   = cnt_q - LEN_WIDTH'(1);
                        state_d = (cnt_q != LEN_WIDTH'(1)) ? S_RD_REQ : S_FINISH;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Every output decodes registered state only, so no input reaches an output combinationally
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FINISH);
    assign error    = error_q;
    assign err_addr = err_addr_q;

    assign data_if.data_req   = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    assign data_if.data_we    = (state_q == S_WR_REQ);
    assign data_if.data_be    = data_if.data_req ? '1 : '0;
    assign data_if.data_wdata = wdata_q;
    assign data_if.data_addr  = ((state_q == S_RD_REQ) || (state_q == S_RD_WAIT)) ? src_q :
                                ((state_q == S_WR_REQ) || (state_q == S_WR_WAIT)) ? dst_q : '0;
endmodule

// File: tb/tb_mem_copy_initiator.sv
// tb/tb_mem_copy_initiator.sv - self-checking bench for mem_copy_initiator
module tb_mem_copy_initiator;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len_words;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] err_addr;

    mem_copy_initiator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_copy_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_addr  (err_addr),
        .data_if   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } tx_t;

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        int            len;
        int            g;
        int            r;
        bit            ie;
        logic [AW-1:0] ia;
        int            restart;
        int            exp_ntx;
        bit            exp_err;
        logic [AW-1:0] exp_ea;
        int            exp_done;
    } vec_t;

    int            checks = 0;
    int            failures = 0;
    tx_t           log_q[$];
    tx_t           exp_q[$];
    int            log_base;
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [AW-1:0] m_err_addr;

    int            gnt_wait, rsp_wait, rsp_cnt, stall_cnt;
    bit            inj_en, spur_en, outstanding, stalled_prev, pend_err;
    logic [AW-1:0] inj_addr;
    logic [DW-1:0] pend_data;
    tx_t           snap;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        if (a >= 32'h100 && a < 32'h10C) return DW'(32'hA0 + ((a - 32'h100) >> 2));
        return DW'(a * 32'h9E3779B9) ^ DW'(32'h5A5A0000);
    endfunction

    // Reference: walk the words in order, stop at the first failing access
    function automatic void model(input logic [AW-1:0] s_in, input logic [AW-1:0] d_in,
                                  input int len, input bit ie, input logic [AW-1:0] ia,
                                  output bit e);
        logic [DW-1:0] mm [logic [AW-1:0]];
        logic [AW-1:0] s, d, a, b;
        logic [DW-1:0] rd;
        mm = mem;
        exp_q.delete();
        e = 1'b0;
        s = s_in & ~AW'(DW / 8 - 1);
        d = d_in & ~AW'(DW / 8 - 1);
        for (int i = 0; i < len; i++) begin
            a  = s + AW'(i * (DW / 8));
            b  = d + AW'(i * (DW / 8));
            rd = mm.exists(a) ? mm[a] : dflt(a);
            exp_q.push_back('{1'b0, a, rd});
            if (ie && a == ia) begin e = 1'b1; m_err_addr = a; break; end
            exp_q.push_back('{1'b1, b, rd});
            if (ie && b == ia) begin e = 1'b1; m_err_addr = b; break; end
            mm[b] = rd;
        end
    endfunction

    // One negedge: advance the memory responder, then return to the caller
    task automatic tick();
        tx_t t;
        bit  hit;
        @(negedge clk);
        bus.data_gnt    = 1'b0;
        bus.data_rvalid = 1'b0;
        bus.data_err    = 1'b0;
        bus.data_rdata  = DW'($urandom);
        if (rst) begin
            outstanding  = 1'b0;
            stall_cnt    = 0;
            stalled_prev = 1'b0;
        end else if (outstanding) begin
            if (rsp_cnt == 0) begin
                bus.data_rvalid = 1'b1;
                bus.data_err    = pend_err;
                bus.data_rdata  = pend_data;
                outstanding     = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end else begin
            if (stalled_prev) chk("req_held", 64'(bus.data_req), 64'(1));
            if (bus.data_req) begin
                chk("be_all_ones", 64'(bus.data_be), 64'({(DW / 8){1'b1}}));
                if (stall_cnt == 0) begin
                    snap = '{bus.data_we, bus.data_addr, bus.data_wdata};
                end else begin
                    chk("stall_addr", 64'(bus.data_addr), 64'(snap.addr));
                    chk("stall_we", 64'(bus.data_we), 64'(snap.we));
                    chk("stall_wdata", 64'(bus.data_wdata), 64'(snap.data));
                end
                if (stall_cnt >= gnt_wait) begin
                    bus.data_gnt = 1'b1;
                    hit = inj_en && (bus.data_addr == inj_addr);
                    t.we   = bus.data_we;
                    t.addr = bus.data_addr;
                    if (bus.data_we) begin
                        t.data    = bus.data_wdata;
                        pend_data = DW'($urandom);
                        if (!hit) mem[bus.data_addr] = bus.data_wdata;
                    end else begin
                        t.data    = mem.exists(bus.data_addr) ? mem[bus.data_addr] : dflt(bus.data_addr);
                        pend_data = t.data;
                    end
                    log_q.push_back(t);
                    pend_err     = hit;
                    outstanding  = 1'b1;
                    rsp_cnt      = rsp_wait;
                    stall_cnt    = 0;
                    stalled_prev = 1'b0;
                end else begin
                    stall_cnt++;
                    stalled_prev = 1'b1;
                end
            end else begin
                stalled_prev = 1'b0;
                if (spur_en && $urandom_range(0, 3) == 0) begin
                    bus.data_rvalid = 1'b1;
                    bus.data_err    = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_error"}, 64'(error), 64'(0));
        chk({tag, "_err_addr"}, 64'(err_addr), 64'(0));
        chk({tag, "_req"}, 64'(bus.data_req), 64'(0));
        chk({tag, "_addr"}, 64'(bus.data_addr), 64'(0));
        chk({tag, "_we"}, 64'(bus.data_we), 64'(0));
        chk({tag, "_be"}, 64'(bus.data_be), 64'(0));
        chk({tag, "_wdata"}, 64'(bus.data_wdata), 64'(0));
    endtask

    task automatic run_case(input string nm, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int len, input int g, input int r, input bit ie,
                            input logic [AW-1:0] ia, input int restart_cyc,
                            output int n_tx, output bit got_err, output logic [AW-1:0] got_ea,
                            output int done_cyc);
        bit e_exp;
        int cyc, ndone, nbusy, exp_done;
        gnt_wait = g;
        rsp_wait = r;
        inj_en   = ie;
        inj_addr = ia;
        model(s, d, len, ie, ia, e_exp);
        exp_done  = 2 + exp_q.size() * (2 + g + r);
        log_base  = log_q.size();
        start     = 1'b1;
        src_addr  = s;
        dst_addr  = d;
        len_words = LW'(len);
        cyc = 1; done_cyc = 0; ndone = 0; nbusy = 0;
        while (cyc < 600 && !(ndone > 0 && cyc > done_cyc + 3)) begin
            tick();
            cyc++;
            start = (cyc == restart_cyc);
            if (start) begin
                src_addr  = s ^ 32'h0000_8000;
                dst_addr  = d ^ 32'h0001_0000;
                len_words = LW'(len + 5);
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    chk({nm, "_busy_at_done"}, 64'(busy), 64'(1));
                end
            end
            if (ndone > 0 && cyc == done_cyc + 1) chk({nm, "_busy_after_done"}, 64'(busy), 64'(0));
        end
        start   = 1'b0;
        n_tx    = log_q.size() - log_base;
        got_err = error;
        got_ea  = err_addr;
        chk({nm, "_done_pulses"}, 64'(ndone), 64'(1));
        chk({nm, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        chk({nm, "_busy_cycles"}, 64'(nbusy), 64'(exp_done - 1));
        chk({nm, "_ntx"}, 64'(n_tx), 64'(exp_q.size()));
        for (int i = 0; i < n_tx && i < exp_q.size(); i++) begin
            chk({nm, "_tx_we"}, 64'(log_q[log_base + i].we), 64'(exp_q[i].we));
            chk({nm, "_tx_addr"}, 64'(log_q[log_base + i].addr), 64'(exp_q[i].addr));
            chk({nm, "_tx_data"}, 64'(log_q[log_base + i].data), 64'(exp_q[i].data));
        end
        chk({nm, "_error"}, 64'(got_err), 64'(e_exp));
        chk({nm, "_err_addr"}, 64'(got_ea), 64'(m_err_addr));
    endtask

    initial begin
        vec_t          vt[6];
        int            n_tx, done_cyc, len, wait_n;
        bit            got_err, ie;
        logic [AW-1:0] got_ea, s, d, ia;

        vt[0] = '{32'h100, 32'h200, 3, 0, 0, 1'b0, 32'h0, 0, 6, 1'b0, 32'h0, 14};
        vt[1] = '{32'h300, 32'h400, 2, 3, 0, 1'b0, 32'h0, 0, 4, 1'b0, 32'h0, 22};
        vt[2] = '{32'h100, 32'h200, 4, 0, 0, 1'b1, 32'h104, 0, 3, 1'b1, 32'h104, 8};
        vt[3] = '{32'hFFFF_FFFC, 32'h10, 2, 0, 1, 1'b0, 32'h0, 4, 4, 1'b0, 32'h104, 14};
        vt[4] = '{32'h503, 32'h602, 3, 1, 2, 1'b1, 32'h604, 0, 4, 1'b1, 32'h604, 22};
        vt[5] = '{32'h700, 32'h800, 0, 0, 0, 1'b0, 32'h0, 0, 0, 1'b0, 32'h604, 2};

        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
        gnt_wait = 0; rsp_wait = 0; inj_en = 1'b0; inj_addr = '0; spur_en = 1'b0;
        outstanding = 1'b0; stall_cnt = 0; stalled_prev = 1'b0; m_err_addr = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        foreach (vt[i]) begin
            run_case($sformatf("vec%0d", i), vt[i].src, vt[i].dst, vt[i].len, vt[i].g, vt[i].r,
                     vt[i].ie, vt[i].ia, vt[i].restart, n_tx, got_err, got_ea, done_cyc);
            chk($sformatf("vec%0d_tab_ntx", i), 64'(n_tx), 64'(vt[i].exp_ntx));
            chk($sformatf("vec%0d_tab_error", i), 64'(got_err), 64'(vt[i].exp_err));
            chk($sformatf("vec%0d_tab_err_addr", i), 64'(got_ea), 64'(vt[i].exp_ea));
            chk($sformatf("vec%0d_tab_done", i), 64'(done_cyc), 64'(vt[i].exp_done));
            if (i == 3 && n_tx > 2) chk("wrap_second_read", 64'(log_q[log_base + 2].addr), 64'(0));
        end

        // Reset while the first write is outstanding
        gnt_wait = 0; rsp_wait = 6; inj_en = 1'b0;
        log_base = log_q.size();
        start = 1'b1; src_addr = 32'h1000; dst_addr = 32'h2000; len_words = LW'(3);
        tick();
        start = 1'b0;
        wait_n = 0;
        while (wait_n < 50 && !(log_q.size() - log_base == 2 && outstanding)) begin
            tick();
            wait_n++;
        end
        chk("reached_wr_wait", 64'(log_q.size() - log_base), 64'(2));
        rst = 1'b1;
        tick();
        chk_zero("mid_reset");
        tick();
        rst = 1'b0;
        m_err_addr = '0;
        tick();
        run_case("after_reset", 32'h1000, 32'h2000, 3, 0, 0, 1'b0, 32'h0, 0,
                 n_tx, got_err, got_ea, done_cyc);

        spur_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            s   = $urandom;
            d   = ($urandom_range(0, 3) == 0) ? s + AW'(4 * $urandom_range(0, 3)) : AW'($urandom);
            len = $urandom_range(0, 5);
            ie  = (len > 0) && ($urandom_range(0, 2) == 0);
            ia  = (($urandom_range(0, 1) == 0) ? s : d) & ~AW'(3);
            ia  = ia + AW'(4 * $urandom_range(0, (len > 0) ? len - 1 : 0));
            run_case($sformatf("rnd%0d", k), s, d, len, $urandom_range(0, 2), $urandom_range(0, 2),
                     ie, ia, (len > 0 && $urandom_range(0, 1) == 1) ? 3 : 0,
                     n_tx, got_err, got_ea, done_cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_copy_initiator.md
Name: mem_copy_initiator

Overview:
- Request-side (initiator) engine for the team's data memory port protocol: req/addr/we/be/wdata out; gnt/rvalid/err/rdata in.
- Copies a block of words from a source address to a destination address over one memory port (e.g. the A port of the dual-port memory wrapper).
- Used for memory preload/scrub and as a self-checking traffic source for memory subsystem bring-up.
- Keeps at most one transaction outstanding. Each word is a read followed by a write.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- LEN_WIDTH, 16, width of the word-count input.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_addr  input  ADDR_WIDTH  source byte address; low $clog2(DATA_WIDTH/8) bits forced to 0.
- dst_addr  input  ADDR_WIDTH  destination byte address; low bits forced to 0.
- len_words  input  LEN_WIDTH  number of words to copy.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at the end of the copy (normal or aborted).
- error  output  1  sticky; set on err response; cleared on the next accepted start.
- err_addr  output  ADDR_WIDTH  byte address of the transaction that returned err.
- data_req  output  1  transaction request.
- data_addr  output  ADDR_WIDTH  word-aligned byte address.
- data_we  output  1  1 = write, 0 = read.
- data_be  output  DATA_WIDTH/8  byte enables; all ones.
- data_wdata  output  DATA_WIDTH  write data (the captured read data).
- data_gnt  input  1  grant; a transaction is accepted in any cycle with data_req && data_gnt.
- data_rvalid  input  1  response valid; arrives at least 1 cycle after the grant.
- data_err  input  1  error flag; meaningful only with data_rvalid.
- data_rdata  input  DATA_WIDTH  read data; meaningful with data_rvalid on reads.

Behaviour:
- Reset values: all outputs are 0, including busy, done, error, err_addr, data_req, data_addr, data_we, data_be, data_wdata. The FSM resets to IDLE. Reset mid-copy aborts immediately, with no done pulse. If data_req was high at reset, it drops the next cycle.
- FSM states:
  - IDLE: waiting for start.
  - RD_REQ: data_req=1, we=0, addr=src pointer.
  - RD_WAIT: waiting for rvalid on the read.
  - WR_REQ: data_req=1, we=1, addr=dst pointer, wdata=captured read data.
  - WR_WAIT: waiting for rvalid on the write.
  - FINISH: one cycle; done=1.
- All bus outputs are registered, driven from the state and the pointer/data registers. No combinational path from any input to any output.
- IDLE transitions:
  - start && len_words!=0 -> RD_REQ. Capture the pointers and the count. Clear error. busy=1.
  - start && len_words==0 -> FINISH. No bus traffic; busy=1 for that one cycle.
- RD_REQ -> RD_WAIT on data_gnt. If gnt is low, stay in RD_REQ with addr/we/be/wdata held stable. Once asserted, data_req is never withdrawn before gnt.
- RD_WAIT on data_rvalid:
  - err=1: set error, err_addr = src pointer, go to FINISH (abort).
  - otherwise: capture data_rdata into the wdata register and go to WR_REQ.
- WR_REQ -> WR_WAIT on data_gnt; stall rules as for RD_REQ.
- WR_WAIT on data_rvalid:
  - err=1: set error, err_addr = dst pointer, go to FINISH.
  - otherwise: src += DATA_WIDTH/8, dst += DATA_WIDTH/8, count -= 1. Go to RD_REQ if the remaining count is nonzero, else FINISH.
- FINISH: done=1, busy=0 on the next cycle, return to IDLE. error stays high until the next accepted start.
- Pointer arithmetic is modulo 2^ADDR_WIDTH; wrap past all-ones is silent.
- data_rvalid in IDLE, RD_REQ, WR_REQ or FINISH is ignored (spurious responses).
- start while busy is ignored: no effect on the pointers or the count.
- Throughput with a zero-wait responder (gnt in the request cycle, rvalid the next cycle): 4 cycles per word.
- Latency from start to the first data_req: 1 cycle. From the last write's rvalid to done: 1 cycle.

Test Plan:
- Zero-wait responder, src=0x100, dst=0x200, len=3, memory words 0xA0,0xA1,0xA2 -> reads at 0x100/0x104/0x108, writes of the same data to 0x200/0x204/0x208. done on cycle 14 after start. error=0.
- Responder holds gnt low for 3 cycles on every request, len=2 -> data_req, data_addr and data_wdata stable through each stall. Exactly 4 transactions. done after completion.
- data_err=1 on the second read (addr 0x104), len=4 -> one write, then abort. error=1, err_addr=0x104, done pulse. No further data_req.
- len_words=0 with start -> no data_req. done pulses 2 cycles after start. busy high for exactly 1 cycle.
- start pulsed again mid-copy with different addresses -> ignored; the original copy completes unchanged. src=0xFFFFFFFC, len=2 -> second read at 0x00000000.
- rst asserted during WR_WAIT -> next cycle all outputs are 0 and the FSM is in IDLE. A new start then performs a clean copy.
